// File: rtl/mem_stage_if.sv
// Pipeline bus between execute (master side), the memory stage (slave side) and writeback.
// Signal names match the original flat port list so existing hookups carry over.
interface mem_stage_if #(
  parameter int REG_WIDTH = 16,
  parameter int PC_WIDTH  = 16
);
  logic                 I_LOCK;
  logic                 I_EX_Valid;
  logic [PC_WIDTH-1:0]  I_PC;
  logic [7:0]           I_Opcode;
  logic [31:0]          I_IR;
  logic [REG_WIDTH-1:0] I_DestValue;
  logic [3:0]           I_DestRegIdx;
  logic                 I_RegWEn;
  logic                 I_CCWEn;
  logic [2:0]           I_CCValue;
  logic [REG_WIDTH-1:0] I_MARValue;
  logic [REG_WIDTH-1:0] I_MDRValue;

  logic                 O_LOCK;
  logic [PC_WIDTH-1:0]  O_PC;
  logic [7:0]           O_Opcode;
  logic [31:0]          O_IR;
  logic                 O_MEM_Valid;
  logic [REG_WIDTH-1:0] O_DestValue;
  logic [3:0]           O_DestRegIdx;
  logic                 O_RegWEn;
  logic                 O_CCWEn;
  logic [2:0]           O_CCValue;
  logic                 O_MemStall_Signal;

  modport master (
    output I_LOCK, I_EX_Valid, I_PC, I_Opcode, I_IR, I_DestValue, I_DestRegIdx,
           I_RegWEn, I_CCWEn, I_CCValue, I_MARValue, I_MDRValue,
    input  O_LOCK, O_PC, O_Opcode, O_IR, O_MEM_Valid, O_DestValue, O_DestRegIdx,
           O_RegWEn, O_CCWEn, O_CCValue, O_MemStall_Signal
  );

  modport slave (
    input  I_LOCK, I_EX_Valid, I_PC, I_Opcode, I_IR, I_DestValue, I_DestRegIdx,
           I_RegWEn, I_CCWEn, I_CCValue, I_MARValue, I_MDRValue,
    output O_LOCK, O_PC, O_Opcode, O_IR, O_MEM_Valid, O_DestValue, O_DestRegIdx,
           O_RegWEn, O_CCWEn, O_CCValue, O_MemStall_Signal
  );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: LDW/LDB/STW/STB against local data memory and MMIO, multi-cycle access
// with a stall to upstream; every other instruction passes through in one cycle.
module mem_stage #(
  parameter int DMEM_WORDS  = 1024,
  parameter int MEM_LATENCY = 2,
  parameter int REG_WIDTH   = 16,
  parameter int PC_WIDTH    = 16
) (
  input  logic        I_CLOCK,
  input  logic        I_RESET,
  mem_stage_if.slave  pipe,
  input  logic [9:0]  I_SW,
  output logic [9:0]  O_LEDR,
  output logic [15:0] O_HEX
);
  localparam logic [7:0] OP_LDB = 8'h48;
  localparam logic [7:0] OP_LDW = 8'h4C;
  localparam logic [7:0] OP_STB = 8'h58;
  localparam logic [7:0] OP_STW = 8'h5C;
  localparam logic [2:0] CC_N = 3'b100;
  localparam logic [2:0] CC_Z = 3'b010;
  localparam logic [2:0] CC_P = 3'b001;
  localparam logic [REG_WIDTH-1:0] ADDR_LEDR = REG_WIDTH'(16'hF000);
  localparam logic [REG_WIDTH-1:0] ADDR_HEX  = REG_WIDTH'(16'hF004);
  localparam logic [REG_WIDTH-1:0] ADDR_SW   = REG_WIDTH'(16'hF008);
  localparam int AW = $clog2(DMEM_WORDS);
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          accept, complete, stall, in_mem;

  logic [REG_WIDTH-1:0] dmem [DMEM_WORDS];

  logic [PC_WIDTH-1:0]  lat_pc, acc_pc;
  logic [7:0]           lat_op, acc_op;
  logic [31:0]          lat_ir, acc_ir;
  logic [REG_WIDTH-1:0] lat_dv, acc_dv, lat_mar, acc_mar, lat_mdr, acc_mdr;
  logic [3:0]           lat_dst, acc_dst;
  logic [2:0]           lat_cc, acc_cc;

  logic [REG_WIDTH-2:0] word_idx;
  logic                 in_range, is_led, is_hex, is_sw, is_mmio, acc_load, acc_store, mem_we;
  logic [REG_WIDTH-1:0] mem_word, raw, ld_data, st_data;
  logic [7:0]           ld_byte;

  function automatic logic is_mem_op(input logic [7:0] op);
    return (op == OP_LDW) || (op == OP_LDB) || (op == OP_STW) || (op == OP_STB);
  endfunction

  function automatic logic [2:0] cc_of(input logic [REG_WIDTH-1:0] d);
    if (d == '0) return CC_Z;
    if (d[REG_WIDTH-1]) return CC_N;
    return CC_P;
  endfunction

  assign in_mem = is_mem_op(pipe.I_Opcode);

  always_ff @(negedge I_CLOCK) begin
    if (I_RESET) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // cnt holds the edges still to go; the access finishes on the edge seen with cnt==1,
  // so the stall covers MEM_LATENCY-1 cycles and the last cycle releases upstream.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    complete = 1'b0;
    stall    = 1'b0;
    unique case (state)
      IDLE: begin
        accept = pipe.I_LOCK && pipe.I_EX_Valid;
        if (accept && in_mem) begin
          if (MEM_LATENCY == 1) begin
            complete = 1'b1;
          end else begin
            state_nx = ACCESS;
            cnt_nx   = CW'(MEM_LATENCY - 1);
            stall    = 1'b1;
          end
        end
      end
      ACCESS: begin
        cnt_nx = cnt - 1'b1;
        if (cnt == CW'(1)) begin
          complete = 1'b1;
          state_nx = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
    endcase
  end

  assign pipe.O_MemStall_Signal = stall && !I_RESET;

  always_comb begin
    if (state == ACCESS) begin
      acc_pc = lat_pc;  acc_op = lat_op;  acc_ir = lat_ir;  acc_dv = lat_dv;
      acc_mar = lat_mar; acc_mdr = lat_mdr; acc_dst = lat_dst; acc_cc = lat_cc;
    end else begin
      acc_pc = pipe.I_PC;  acc_op = pipe.I_Opcode;  acc_ir = pipe.I_IR;
      acc_dv = pipe.I_DestValue; acc_mar = pipe.I_MARValue; acc_mdr = pipe.I_MDRValue;
      acc_dst = pipe.I_DestRegIdx; acc_cc = pipe.I_CCValue;
    end
  end

  always_comb begin
    word_idx  = acc_mar[REG_WIDTH-1:1];
    in_range  = 32'(word_idx) < 32'(DMEM_WORDS);
    mem_word  = in_range ? dmem[word_idx[AW-1:0]] : '0;
    is_led    = acc_mar == ADDR_LEDR;
    is_hex    = acc_mar == ADDR_HEX;
    is_sw     = acc_mar == ADDR_SW;
    is_mmio   = is_led || is_hex || is_sw;
    acc_load  = (acc_op == OP_LDW) || (acc_op == OP_LDB);
    acc_store = (acc_op == OP_STW) || (acc_op == OP_STB);
    if (is_led)      raw = REG_WIDTH'(O_LEDR);
    else if (is_hex) raw = REG_WIDTH'(O_HEX);
    else if (is_sw)  raw = REG_WIDTH'(I_SW);
    else             raw = mem_word;
    ld_byte = acc_mar[0] ? raw[15:8] : raw[7:0];
    ld_data = (acc_op == OP_LDB) ? {{(REG_WIDTH-8){ld_byte[7]}}, ld_byte} : raw;
    if (acc_op == OP_STB) st_data = acc_mar[0] ? {acc_mdr[7:0], mem_word[7:0]}
                                               : {mem_word[15:8], acc_mdr[7:0]};
    else                  st_data = acc_mdr;
    mem_we = complete && acc_store && !is_mmio && in_range && !I_RESET;
  end

  always_ff @(negedge I_CLOCK) begin
    if (mem_we) dmem[word_idx[AW-1:0]] <= st_data;
  end

  always_ff @(negedge I_CLOCK) begin
    if (!I_RESET && accept) begin
      lat_pc  <= pipe.I_PC;         lat_op  <= pipe.I_Opcode;
      lat_ir  <= pipe.I_IR;         lat_dv  <= pipe.I_DestValue;
      lat_mar <= pipe.I_MARValue;   lat_mdr <= pipe.I_MDRValue;
      lat_dst <= pipe.I_DestRegIdx; lat_cc  <= pipe.I_CCValue;
    end
  end

  always_ff @(negedge I_CLOCK) begin
    if (I_RESET) begin
      pipe.O_LOCK       <= 1'b0;
      pipe.O_PC         <= '0;
      pipe.O_Opcode     <= '0;
      pipe.O_IR         <= '0;
      pipe.O_MEM_Valid  <= 1'b0;
      pipe.O_DestValue  <= '0;
      pipe.O_DestRegIdx <= '0;
      pipe.O_RegWEn     <= 1'b0;
      pipe.O_CCWEn      <= 1'b0;
      pipe.O_CCValue    <= '0;
      O_LEDR            <= '0;
      O_HEX             <= '0;
    end else begin
      pipe.O_LOCK <= pipe.I_LOCK;
      if (complete) begin
        pipe.O_PC         <= acc_pc;
        pipe.O_Opcode     <= acc_op;
        pipe.O_IR         <= acc_ir;
        pipe.O_MEM_Valid  <= 1'b1;
        pipe.O_DestRegIdx <= acc_dst;
        if (acc_load) begin
          pipe.O_DestValue <= ld_data;
          pipe.O_RegWEn    <= 1'b1;
          pipe.O_CCWEn     <= 1'b1;
          pipe.O_CCValue   <= cc_of(ld_data);
        end else begin
          pipe.O_DestValue <= acc_dv;
          pipe.O_RegWEn    <= 1'b0;
          pipe.O_CCWEn     <= 1'b0;
          pipe.O_CCValue   <= acc_cc;
        end
        if (acc_store && is_led) O_LEDR <= acc_mdr[9:0];
        if (acc_store && is_hex) O_HEX  <= acc_mdr[15:0];
      end else if (accept && !in_mem) begin
        pipe.O_PC         <= pipe.I_PC;
        pipe.O_Opcode     <= pipe.I_Opcode;
        pipe.O_IR         <= pipe.I_IR;
        pipe.O_MEM_Valid  <= 1'b1;
        pipe.O_DestValue  <= pipe.I_DestValue;
        pipe.O_DestRegIdx <= pipe.I_DestRegIdx;
        pipe.O_RegWEn     <= pipe.I_RegWEn;
        pipe.O_CCWEn      <= pipe.I_CCWEn;
        pipe.O_CCValue    <= pipe.I_CCValue;
      end else begin
        pipe.O_MEM_Valid <= 1'b0;
        pipe.O_RegWEn    <= 1'b0;
        pipe.O_CCWEn     <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against a transaction-level model of memory, MMIO and timing.
module tb_mem_stage;
  localparam int DW  = 1024;
  localparam int LAT = 2;
  localparam int MAW = $clog2(DW);
  localparam logic [7:0] OP_LDB = 8'h48;
  localparam logic [7:0] OP_LDW = 8'h4C;
  localparam logic [7:0] OP_STB = 8'h58;
  localparam logic [7:0] OP_STW = 8'h5C;
  localparam logic [7:0] OP_ADD = 8'h00;
  localparam logic [2:0] CC_N = 3'b100;
  localparam logic [2:0] CC_Z = 3'b010;
  localparam logic [2:0] CC_P = 3'b001;

  logic        clk = 1'b1;
  logic        rst;
  logic [9:0]  sw;
  logic [9:0]  ledr;
  logic [15:0] hex;

  logic [15:0] mdl_mem [DW];
  logic [9:0]  mdl_led;
  logic [15:0] mdl_hex;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  mem_stage_if #(.REG_WIDTH(16), .PC_WIDTH(16)) pipe ();

  mem_stage #(.DMEM_WORDS(DW), .MEM_LATENCY(LAT), .REG_WIDTH(16), .PC_WIDTH(16)) dut (
    .I_CLOCK(clk), .I_RESET(rst), .pipe(pipe.slave),
    .I_SW(sw), .O_LEDR(ledr), .O_HEX(hex)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic is_mem(input logic [7:0] op);
    return op == OP_LDW || op == OP_LDB || op == OP_STW || op == OP_STB;
  endfunction

  function automatic logic [15:0] mdl_load(input logic [7:0] op, input logic [15:0] addr);
    int w, b, idx;
    idx = int'(addr) / 2;
    if (addr == 16'hF000)      w = int'(mdl_led);
    else if (addr == 16'hF004) w = int'(mdl_hex);
    else if (addr == 16'hF008) w = int'(sw);
    else if (idx < DW)         w = int'(mdl_mem[idx[MAW-1:0]]);
    else                       w = 0;
    if (op != OP_LDB) return 16'(w);
    b = addr[0] ? w / 256 : w % 256;
    if (b >= 128) b = b - 256;
    return 16'(b);
  endfunction

  function automatic logic [2:0] mdl_cc(input logic [15:0] d);
    if (d == 16'd0) return CC_Z;
    if (d >= 16'h8000) return CC_N;
    return CC_P;
  endfunction

  function automatic void mdl_store(input logic [7:0] op, input logic [15:0] addr,
                                    input logic [15:0] mdr);
    int idx, old;
    idx = int'(addr) / 2;
    if (addr == 16'hF000)      mdl_led = mdr[9:0];
    else if (addr == 16'hF004) mdl_hex = mdr;
    else if (addr == 16'hF008) return;
    else if (idx < DW) begin
      old = int'(mdl_mem[idx[MAW-1:0]]);
      if (op == OP_STW)  mdl_mem[idx[MAW-1:0]] = mdr;
      else if (addr[0])  mdl_mem[idx[MAW-1:0]] = 16'((old % 256) + int'(mdr[7:0]) * 256);
      else               mdl_mem[idx[MAW-1:0]] = 16'((old / 256) * 256 + int'(mdr[7:0]));
    end
  endfunction

  task automatic check_reset_zero();
    check("rst_flags", 32'({pipe.O_MEM_Valid, pipe.O_RegWEn, pipe.O_CCWEn, pipe.O_LOCK,
                            pipe.O_MemStall_Signal}), 32'(0));
    check("rst_dest", 32'(pipe.O_DestValue), 32'(0));
    check("rst_pc", 32'(pipe.O_PC), 32'(0));
    check("rst_ir", pipe.O_IR, 32'(0));
    check("rst_misc", 32'({pipe.O_Opcode, pipe.O_DestRegIdx, pipe.O_CCValue}), 32'(0));
    check("rst_mmio", 32'({ledr, hex}), 32'(0));
  endtask

  task automatic issue_mem(input logic [7:0] op, input logic [15:0] addr, input logic [15:0] mdr,
                           input logic scramble, input logic drop_lock);
    logic [15:0] pc, exp_d;
    logic [3:0]  dst;
    pc  = 16'($urandom);
    dst = 4'($urandom);
    pipe.I_LOCK = 1'b1; pipe.I_EX_Valid = 1'b1; pipe.I_Opcode = op;
    pipe.I_MARValue = addr; pipe.I_MDRValue = mdr; pipe.I_PC = pc; pipe.I_IR = $urandom;
    pipe.I_DestValue = 16'($urandom); pipe.I_DestRegIdx = dst; pipe.I_RegWEn = 1'($urandom);
    pipe.I_CCWEn = 1'($urandom); pipe.I_CCValue = 3'($urandom);
    exp_d = mdl_load(op, addr);
    for (int k = 0; k < LAT - 1; k++) begin
      #1 check("stall_busy", 32'(pipe.O_MemStall_Signal), 32'(1));
      step();
      check("bubble_valid", 32'(pipe.O_MEM_Valid), 32'(0));
      check("bubble_we", 32'({pipe.O_RegWEn, pipe.O_CCWEn}), 32'(0));
      if (k == 0 && scramble) begin
        pipe.I_MARValue = 16'($urandom); pipe.I_MDRValue = 16'($urandom);
        pipe.I_PC = 16'($urandom); pipe.I_Opcode = OP_ADD; pipe.I_DestRegIdx = 4'($urandom);
      end
      if (k == 0 && drop_lock) pipe.I_LOCK = 1'b0;
    end
    #1 check("stall_last", 32'(pipe.O_MemStall_Signal), 32'(0));
    step();
    check("mem_valid", 32'(pipe.O_MEM_Valid), 32'(1));
    check("mem_pc", 32'(pipe.O_PC), 32'(pc));
    check("mem_dst", 32'(pipe.O_DestRegIdx), 32'(dst));
    if (op == OP_LDW || op == OP_LDB) begin
      check("ld_data", 32'(pipe.O_DestValue), 32'(exp_d));
      check("ld_we", 32'({pipe.O_RegWEn, pipe.O_CCWEn}), 32'(3));
      check("ld_cc", 32'(pipe.O_CCValue), 32'(mdl_cc(exp_d)));
    end else begin
      check("st_we", 32'({pipe.O_RegWEn, pipe.O_CCWEn}), 32'(0));
      mdl_store(op, addr, mdr);
    end
    check("ledr", 32'(ledr), 32'(mdl_led));
    check("hex", 32'(hex), 32'(mdl_hex));
    pipe.I_EX_Valid = 1'b0;
  endtask

  task automatic issue_alu(input logic [7:0] op, input logic [15:0] dv, input logic [1:0] we);
    logic [15:0] pc;
    logic [31:0] ir;
    logic [3:0]  dst;
    logic [2:0]  cc;
    pc = 16'($urandom); ir = $urandom; dst = 4'($urandom); cc = 3'($urandom);
    pipe.I_LOCK = 1'b1; pipe.I_EX_Valid = 1'b1; pipe.I_Opcode = op; pipe.I_PC = pc;
    pipe.I_IR = ir; pipe.I_DestValue = dv; pipe.I_DestRegIdx = dst;
    pipe.I_RegWEn = we[1]; pipe.I_CCWEn = we[0]; pipe.I_CCValue = cc;
    pipe.I_MARValue = 16'($urandom); pipe.I_MDRValue = 16'($urandom);
    #1 check("alu_stall", 32'(pipe.O_MemStall_Signal), 32'(0));
    step();
    check("alu_valid", 32'(pipe.O_MEM_Valid), 32'(1));
    check("alu_dest", 32'(pipe.O_DestValue), 32'(dv));
    check("alu_we", 32'({pipe.O_RegWEn, pipe.O_CCWEn}), 32'(we));
    check("alu_tag", 32'({pipe.O_Opcode, pipe.O_DestRegIdx, pipe.O_CCValue, pipe.O_PC}),
          32'({op, dst, cc, pc}));
    check("alu_ir", pipe.O_IR, ir);
    pipe.I_EX_Valid = 1'b0;
  endtask

  task automatic idle_cycle(input logic lock);
    pipe.I_LOCK = lock; pipe.I_EX_Valid = !lock;
    pipe.I_Opcode = OP_STW; pipe.I_MARValue = 16'hF000; pipe.I_MDRValue = 16'($urandom);
    #1 check("idle_stall", 32'(pipe.O_MemStall_Signal), 32'(0));
    step();
    check("idle_valid", 32'(pipe.O_MEM_Valid), 32'(0));
    check("idle_we", 32'({pipe.O_RegWEn, pipe.O_CCWEn}), 32'(0));
    check("idle_lock", 32'(pipe.O_LOCK), 32'(lock));
    check("idle_ledr", 32'(ledr), 32'(mdl_led));
    pipe.I_EX_Valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1);
  end

  initial begin
    logic [7:0]  op;
    logic [15:0] addr;
    int          kind;
    rst = 1'b1; sw = '0; mdl_led = '0; mdl_hex = '0;
    pipe.I_LOCK = 1'b0; pipe.I_EX_Valid = 1'b0; pipe.I_Opcode = OP_ADD; pipe.I_PC = '0;
    pipe.I_IR = '0; pipe.I_DestValue = '0; pipe.I_DestRegIdx = '0; pipe.I_RegWEn = 1'b0;
    pipe.I_CCWEn = 1'b0; pipe.I_CCValue = '0; pipe.I_MARValue = '0; pipe.I_MDRValue = '0;
    repeat (3) step();
    check_reset_zero();
    rst = 1'b0;

    for (int i = 0; i < 64; i++) issue_mem(OP_STW, 16'(i * 2), 16'($urandom), 1'b0, 1'b0);

    issue_alu(OP_ADD, 16'h1234, 2'b11);

    // reset lands on what would have been the STW commit edge
    pipe.I_LOCK = 1'b1; pipe.I_EX_Valid = 1'b1; pipe.I_Opcode = OP_STW;
    pipe.I_MARValue = 16'h0010; pipe.I_MDRValue = 16'hBEEF;
    #1 check("rstmid_stall", 32'(pipe.O_MemStall_Signal), 32'(1));
    step();
    rst = 1'b1; pipe.I_EX_Valid = 1'b0; pipe.I_LOCK = 1'b0;
    step();
    check_reset_zero();
    rst = 1'b0; mdl_led = '0; mdl_hex = '0;
    issue_mem(OP_LDW, 16'h0010, 16'h0, 1'b0, 1'b0);

    issue_mem(OP_STW, 16'h0020, 16'hA5C3, 1'b0, 1'b0);
    issue_mem(OP_LDW, 16'h0020, 16'h0, 1'b0, 1'b0);
    check("tp_ldw", 32'({pipe.O_DestValue, pipe.O_CCValue}), 32'({16'hA5C3, CC_N}));
    issue_mem(OP_STB, 16'h0021, 16'h0007, 1'b0, 1'b0);
    issue_mem(OP_LDB, 16'h0021, 16'h0, 1'b0, 1'b0);
    check("tp_ldb_hi", 32'({pipe.O_DestValue, pipe.O_CCValue}), 32'({16'h0007, CC_P}));
    issue_mem(OP_LDB, 16'h0020, 16'h0, 1'b0, 1'b0);
    check("tp_ldb_lo", 32'(pipe.O_DestValue), 32'(16'hFFC3));
    issue_mem(OP_LDW, 16'h0020, 16'h0, 1'b1, 1'b1);
    check("tp_ldw_merged", 32'(pipe.O_DestValue), 32'(16'h07C3));

    issue_mem(OP_STW, 16'hF000, 16'h03FF, 1'b0, 1'b0);
    check("tp_ledr", 32'(ledr), 32'(10'h3FF));
    sw = 10'h155;
    issue_mem(OP_LDW, 16'hF008, 16'h0, 1'b0, 1'b0);
    check("tp_sw", 32'(pipe.O_DestValue), 32'(16'h0155));
    issue_mem(OP_STW, 16'hF004, 16'h5A5A, 1'b0, 1'b0);
    issue_mem(OP_LDW, 16'hF004, 16'h0, 1'b0, 1'b0);
    issue_mem(OP_LDW, 16'hF000, 16'h0, 1'b0, 1'b0);

    issue_mem(OP_LDW, 16'(DW * 2), 16'h0, 1'b0, 1'b0);
    check("tp_oor", 32'({pipe.O_DestValue, pipe.O_CCValue}), 32'({16'h0000, CC_Z}));
    issue_mem(OP_STW, 16'(DW * 2), 16'hDEAD, 1'b0, 1'b0);
    issue_mem(OP_LDW, 16'h0000, 16'h0, 1'b0, 1'b0);
    idle_cycle(1'b0);
    idle_cycle(1'b1);

    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      sw = 10'($urandom);
      case ($urandom_range(0, 3))
        0: op = OP_LDW;
        1: op = OP_LDB;
        2: op = OP_STW;
        default: op = OP_STB;
      endcase
      if (kind <= 4) begin
        issue_mem(op, 16'($urandom_range(0, 127)), 16'($urandom), 1'($urandom),
                  $urandom_range(0, 7) == 0);
      end else if (kind == 5) begin
        issue_mem(op, 16'($urandom_range(DW * 2, 16'hEFFF)), 16'($urandom), 1'b0, 1'b0);
      end else if (kind == 6) begin
        case ($urandom_range(0, 2))
          0: addr = 16'hF000;
          1: addr = 16'hF004;
          default: addr = 16'hF008;
        endcase
        issue_mem($urandom_range(0, 1) == 1 ? OP_STW : OP_LDW, addr, 16'($urandom), 1'b0, 1'b0);
      end else if (kind <= 8) begin
        do op = 8'($urandom); while (is_mem(op));
        issue_alu(op, 16'($urandom), 2'($urandom));
      end else begin
        idle_cycle(1'($urandom));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
